// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, the
// boot PC and the fetch FSM state encoding.
package if_fetch_pkg;

    localparam int          ADDR_BUS = 32;
    localparam int          INST_BUS = 32;
    localparam logic [31:0] INIT_PC  = 32'hBFC0_0000;

    // S_REQ : request on the bus for pc (or, with the address check,
    //         parked on a misaligned pc waiting for a flush)
    // S_HOLD: word fetched while the pipeline was stalled, kept in a buffer
    // S_DROP: flushed while a request was outstanding; its ack is discarded
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_next_pc.sv
// Sequential-or-branch next PC selection (pc+4 wraps modulo 2^W).
module fetch_next_pc #(
    parameter int W = 32
) (
    input  logic [W-1:0] pc_i,
    input  logic         branch_flag_i,
    input  logic [W-1:0] branch_addr_i,
    output logic [W-1:0] next_pc_o
);

    assign next_pc_o = branch_flag_i ? branch_addr_i : (pc_i + W'(4));

endmodule

// File: rtl/if_fetch.sv
// IF stage and IF/ID register. Owns the PC, fetches over a req/ack ROM bus,
// applies ID branch redirects and CP0 flushes.
// Handshake: inst_req is held with inst_addr stable until the one-cycle
// inst_ack, which carries inst_rdata in that same cycle.
// Optional: IF_ADDR_CHECK_EN raises id_adel for a misaligned pc instead of
// fetching; without it id_adel is 0 and the low pc bits are ignored.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_BUS,
    parameter int                    INST_WIDTH = INST_BUS,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(INIT_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    input  logic                  next_inst_delayslot,
    output logic                  inst_req,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_ack,
    input  logic [INST_WIDTH-1:0] inst_rdata,
    output logic                  fetch_stall_request,
    output logic [ADDR_WIDTH-1:0] id_addr,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic                  id_delayslot,
    output logic                  id_adel,
    output fetch_state_e          dbg_state
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] drop_addr_q;
    logic [INST_WIDTH-1:0] buf_q;
    logic [ADDR_WIDTH-1:0] id_addr_q;
    logic [INST_WIDTH-1:0] id_inst_q;
    logic                  id_ds_q;

    logic [ADDR_WIDTH-1:0] next_pc;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  misaligned;
    logic                  load_req, hold_go, hold_load, adel_load;

`ifdef IF_ADDR_CHECK_EN
    assign misaligned = (state_q == S_REQ) && (pc_q[1:0] != 2'b00);
    assign fetch_addr = pc_q;
`else
    assign misaligned = 1'b0;
    assign fetch_addr = {pc_q[ADDR_WIDTH-1:2], 2'b00};
`endif

    fetch_next_pc #(.W(ADDR_WIDTH)) u_next_pc (
        .pc_i          (pc_q),
        .branch_flag_i (branch_flag),
        .branch_addr_i (branch_addr),
        .next_pc_o     (next_pc)
    );

    // IF/ID load and buffer-capture conditions; flush overrides all of them
    assign load_req  = (state_q == S_REQ)  && !flush && !misaligned && inst_ack && !stall;
    assign hold_go   = (state_q == S_REQ)  && !flush && !misaligned && inst_ack &&  stall;
    assign hold_load = (state_q == S_HOLD) && !flush && !stall;
    assign adel_load = (state_q == S_REQ)  && !flush &&  misaligned && !stall;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_REQ;
        else      state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (flush)                      state_d = (inst_ack || misaligned) ? S_REQ : S_DROP;
                else if (hold_go)               state_d = S_HOLD;
            end
            S_HOLD: begin
                if (flush || !stall)            state_d = S_REQ;
            end
            S_DROP: begin
                if (inst_ack)                   state_d = S_REQ;
            end
            default:                            state_d = S_REQ;
        endcase
    end

    // FSM outputs: bus request, address and pipeline stall request
    always_comb begin
        inst_req            = 1'b0;
        inst_addr           = fetch_addr;
        fetch_stall_request = 1'b0;
        case (state_q)
            S_REQ: begin
                inst_req            = !misaligned;
                fetch_stall_request = !misaligned && !inst_ack;
            end
            S_DROP: begin
                inst_req  = 1'b1;
                inst_addr = drop_addr_q;
            end
            default: ;
        endcase
    end

    // PC, old-request address and stall buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            buf_q       <= '0;
        end else begin
            if (flush)                      pc_q <= flush_pc;
            else if (load_req || hold_load) pc_q <= next_pc;
            if (state_q == S_REQ)           drop_addr_q <= fetch_addr;
            if (hold_go)                    buf_q <= inst_rdata;
        end
    end

    // IF/ID register: bubble on flush, otherwise load on a completed fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_addr_q <= '0;
            id_inst_q <= '0;
            id_ds_q   <= 1'b0;
        end else if (flush) begin
            id_addr_q <= '0;
            id_inst_q <= '0;
            id_ds_q   <= 1'b0;
        end else if (load_req || hold_load || adel_load) begin
            id_addr_q <= pc_q;
            id_inst_q <= load_req ? inst_rdata : (hold_load ? buf_q : '0);
            id_ds_q   <= next_inst_delayslot;
        end
    end

`ifdef IF_ADDR_CHECK_EN
    logic id_adel_q;

    // Address-error flag travels with the IF/ID entry it belongs to
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            id_adel_q <= 1'b0;
        else if (flush)                      id_adel_q <= 1'b0;
        else if (load_req || hold_load)      id_adel_q <= 1'b0;
        else if (adel_load)                  id_adel_q <= 1'b1;
    end

    assign id_adel = id_adel_q;
`else
    assign id_adel = 1'b0;
`endif

    assign id_addr      = id_addr_q;
    assign id_inst      = id_inst_q;
    assign id_delayslot = id_ds_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: sequential fetch, ack latency, branch with
// delay slot, stall hold, flush with drop, PC wrap, misaligned branch
// (IF_ADDR_CHECK_EN selects which behaviour is expected) and async reset.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall, flush, branch_flag, next_inst_delayslot, inst_ack;
    logic [31:0]  flush_pc, branch_addr, inst_rdata;
    logic         inst_req, fetch_stall_request, id_delayslot, id_adel;
    logic [31:0]  inst_addr, id_addr, id_inst;
    fetch_state_e dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .flush               (flush),
        .flush_pc            (flush_pc),
        .branch_flag         (branch_flag),
        .branch_addr         (branch_addr),
        .next_inst_delayslot (next_inst_delayslot),
        .inst_req            (inst_req),
        .inst_addr           (inst_addr),
        .inst_ack            (inst_ack),
        .inst_rdata          (inst_rdata),
        .fetch_stall_request (fetch_stall_request),
        .id_addr             (id_addr),
        .id_inst             (id_inst),
        .id_delayslot        (id_delayslot),
        .id_adel             (id_adel),
        .dbg_state           (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] a, input logic [31:0] i, input logic ds);
        check({tag, "_addr"}, id_addr, a);
        check({tag, "_inst"}, id_inst, i);
        check({tag, "_ds"}, 32'(id_delayslot), 32'(ds));
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
        branch_flag = 1'b0; branch_addr = '0; next_inst_delayslot = 1'b0;
        inst_ack = 1'b0; inst_rdata = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_id("rst", 32'h0, 32'h0, 1'b0);
        check("rst_adel", 32'(id_adel), 32'h0);
        check("rst_req", 32'(inst_req), 32'h1);
        check("rst_iaddr", inst_addr, 32'hBFC0_0000);
        check("rst_state", 32'(dbg_state), 32'(S_REQ));
        rst = 1'b1;

        // 1: back-to-back fetch
        inst_ack = 1'b1; inst_rdata = 32'h1111_0000;
        settle();
        check("t1_fsr", 32'(fetch_stall_request), 32'h0);
        tick();
        check_id("t1_a", 32'hBFC0_0000, 32'h1111_0000, 1'b0);
        check("t1_iaddr1", inst_addr, 32'hBFC0_0004);
        inst_rdata = 32'h1111_0004;
        tick();
        check_id("t1_b", 32'hBFC0_0004, 32'h1111_0004, 1'b0);
        inst_rdata = 32'h1111_0008;
        tick();
        check_id("t1_c", 32'hBFC0_0008, 32'h1111_0008, 1'b0);
        check("t1_iaddr3", inst_addr, 32'hBFC0_000C);

        // 2: ack delayed three cycles
        inst_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t2_fsr", 32'(fetch_stall_request), 32'h1);
            check("t2_iaddr", inst_addr, 32'hBFC0_000C);
            check("t2_idaddr", id_addr, 32'hBFC0_0008);
            tick();
        end
        inst_ack = 1'b1; inst_rdata = 32'h1111_000C;
        settle();
        check("t2_fsr_ack", 32'(fetch_stall_request), 32'h0);
        tick();
        check_id("t2", 32'hBFC0_000C, 32'h1111_000C, 1'b0);

        // 3: branch from ID while the delay slot is acked
        inst_rdata = 32'h1111_0010; branch_flag = 1'b1;
        branch_addr = 32'h8000_0100; next_inst_delayslot = 1'b1;
        tick();
        check_id("t3", 32'hBFC0_0010, 32'h1111_0010, 1'b1);
        check("t3_iaddr", inst_addr, 32'h8000_0100);
        branch_flag = 1'b0; next_inst_delayslot = 1'b0;

        // 4: stall in the ack cycle, held two cycles
        inst_rdata = 32'h2222_0100; stall = 1'b1;
        tick();
        check("t4_state", 32'(dbg_state), 32'(S_HOLD));
        check("t4_req0", 32'(inst_req), 32'h0);
        check("t4_idaddr0", id_addr, 32'hBFC0_0010);
        inst_ack = 1'b0; inst_rdata = 32'hFFFF_FFFF;
        tick();
        check("t4_req1", 32'(inst_req), 32'h0);
        check("t4_idinst1", id_inst, 32'h1111_0010);
        stall = 1'b0;
        tick();
        check_id("t4", 32'h8000_0100, 32'h2222_0100, 1'b0);
        check("t4_state_req", 32'(dbg_state), 32'(S_REQ));
        check("t4_req", 32'(inst_req), 32'h1);
        check("t4_iaddr", inst_addr, 32'h8000_0104);

        // 5: flush with a request outstanding and no ack
        flush = 1'b1; flush_pc = 32'hBFC0_0380;
        settle();
        check("t5_fsr", 32'(fetch_stall_request), 32'h1);
        tick();
        check_id("t5_bub", 32'h0, 32'h0, 1'b0);
        check("t5_state", 32'(dbg_state), 32'(S_DROP));
        check("t5_req", 32'(inst_req), 32'h1);
        check("t5_old_iaddr", inst_addr, 32'h8000_0104);
        flush = 1'b0; inst_ack = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        tick();
        check("t5_state_req", 32'(dbg_state), 32'(S_REQ));
        check("t5_discard", id_inst, 32'h0);
        check("t5_new_iaddr", inst_addr, 32'hBFC0_0380);
        inst_rdata = 32'h3333_0380;
        tick();
        check_id("t5", 32'hBFC0_0380, 32'h3333_0380, 1'b0);

        // flush beats stall in an ack cycle; then pc+4 wraps to 0
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC; stall = 1'b1; inst_rdata = 32'h4444_0000;
        tick();
        check("wr_bub", id_inst, 32'h0);
        check("wr_state", 32'(dbg_state), 32'(S_REQ));
        check("wr_iaddr", inst_addr, 32'hFFFF_FFFC);
        flush = 1'b0; stall = 1'b0; inst_rdata = 32'h4444_FFFC;
        tick();
        check_id("wr", 32'hFFFF_FFFC, 32'h4444_FFFC, 1'b0);
        check("wr_iaddr0", inst_addr, 32'h0);

        // 6: branch to a misaligned target
        inst_rdata = 32'h5555_0000; branch_flag = 1'b1; branch_addr = 32'h8000_0102;
        tick();
        check_id("t6_pre", 32'h0, 32'h5555_0000, 1'b0);
        branch_flag = 1'b0;
`ifdef IF_ADDR_CHECK_EN
        inst_ack = 1'b0;
        settle();
        check("t6_req", 32'(inst_req), 32'h0);
        check("t6_fsr", 32'(fetch_stall_request), 32'h0);
        tick();
        check("t6_adel", 32'(id_adel), 32'h1);
        check_id("t6", 32'h8000_0102, 32'h0, 1'b0);
        check("t6_req_wait", 32'(inst_req), 32'h0);
        flush = 1'b1; flush_pc = 32'hBFC0_0380;
        tick();
        flush = 1'b0;
        check("t6_adel_clr", 32'(id_adel), 32'h0);
        check("t6_state", 32'(dbg_state), 32'(S_REQ));
        check("t6_iaddr", inst_addr, 32'hBFC0_0380);
        check("t6_req_back", 32'(inst_req), 32'h1);
`else
        check("t6_req", 32'(inst_req), 32'h1);
        check("t6_iaddr", inst_addr, 32'h8000_0100);
        inst_rdata = 32'h6666_0100;
        tick();
        check_id("t6", 32'h8000_0102, 32'h6666_0100, 1'b0);
        check("t6_adel", 32'(id_adel), 32'h0);
        check("t6_iaddr2", inst_addr, 32'h8000_0104);
`endif

        // asynchronous reset in the middle of a request
        inst_ack = 1'b0;
        settle();
        rst = 1'b0;
        settle();
        check_id("ar", 32'h0, 32'h0, 1'b0);
        check("ar_req", 32'(inst_req), 32'h1);
        check("ar_iaddr", inst_addr, 32'hBFC0_0000);
        tick();
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
